// File: rtl/output_port_scheduler_if.sv
// Request/grant bundle between the input ports and one output-port scheduler.
interface output_port_scheduler_if #(
  parameter int unsigned N_PORTS = 16,
  parameter int unsigned ID_W    = 4
);
  logic [N_PORTS-1:0] req;
  logic               frameo_n;
  logic [N_PORTS-1:0] grant;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [N_PORTS-1:0] busy_n;
  logic               timeout_pulse;

  modport master (
    output req,
    output frameo_n,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  busy_n,
    input  timeout_pulse
  );

  modport slave (
    input  req,
    input  frameo_n,
    output grant,
    output grant_valid,
    output grant_id,
    output busy_n,
    output timeout_pulse
  );
endinterface

// File: rtl/output_port_scheduler.sv
// Round-robin owner selection for one router output port; the grant is held
// for the whole frame and revoked if the winner never starts sending.
module output_port_scheduler #(
  parameter int unsigned N_PORTS      = 16,
  parameter int unsigned WAIT_TIMEOUT = 15,
  parameter int unsigned TO_W         = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output_port_scheduler_if.slave   bus
);

  localparam int unsigned ID_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACTIVE  = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic               valid_q, valid_d;
  logic [N_PORTS-1:0] busy_n_q, busy_n_d;
  logic               to_q, to_d;

  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    idx;
  logic [N_PORTS-1:0] winner_oh;

  // First requester at or after ptr, wrapping 15 -> 0.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < int'(N_PORTS); k++) begin
      idx = ptr_q + ID_W'(k);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    winner_oh = N_PORTS'(1) << winner;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    gid_d    = gid_q;
    valid_d  = valid_q;
    busy_n_d = busy_n_q;
    to_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d  = winner_oh;
          gid_d    = winner;
          valid_d  = 1'b1;
          busy_n_d = winner_oh;  // only the owner reads not-busy
          cnt_d    = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.frameo_n) begin
          state_d = S_ACTIVE;
        end else if (!bus.req[gid_q]) begin
          grant_d  = '0;
          valid_d  = 1'b0;
          busy_n_d = '1;
          state_d  = S_RELEASE;
        end else if (cnt_q == TO_W'(WAIT_TIMEOUT - 1)) begin
          grant_d  = '0;
          valid_d  = 1'b0;
          busy_n_d = '1;
          to_d     = 1'b1;
          state_d  = S_RELEASE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_ACTIVE: begin
        if (bus.frameo_n) begin
          grant_d  = '0;
          valid_d  = 1'b0;
          busy_n_d = '1;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        ptr_d   = gid_q + ID_W'(1);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      gid_q    <= '0;
      valid_q  <= 1'b0;
      busy_n_q <= '1;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      gid_q    <= gid_d;
      valid_q  <= valid_d;
      busy_n_q <= busy_n_d;
      to_q     <= to_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = valid_q;
  assign bus.grant_id      = gid_q;
  assign bus.busy_n        = busy_n_q;
  assign bus.timeout_pulse = to_q;

endmodule
